// File: rtl/sw_scan_sched_if.sv
// Request/acknowledge handshake between the scan sequencer and the switch controller.
interface sw_scan_sched_if;
    logic [1:0] sw_req;
    logic       sw_ack;

    modport master (output sw_req, input sw_ack);
    modport slave  (input sw_req, output sw_ack);
endinterface

// File: rtl/sw_scan_sched.sv
// Switch scan sequencer: walks a programmed list of x/y switching steps over the
// sw_req/sw_ack handshake. Optional macro SW_SCAN_SCHED_LOOP_EN repeats passes until abort/timeout.
module sw_scan_sched #(
    parameter  int STEP_MAX = 16,
    parameter  int CNT_W    = 32,
    localparam int IDX_W    = $clog2(STEP_MAX)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [IDX_W:0]      reg_step_num_i,
    input  logic [STEP_MAX-1:0] reg_axis_seq_i,
    input  logic [CNT_W-1:0]    reg_dwell_time_i,
    input  logic [CNT_W-1:0]    reg_timeout_i,
    sw_scan_sched_if.master     sw_if,
    output logic                busy_o,
    output logic [IDX_W-1:0]    step_idx_o,
    output logic                step_done_o,
    output logic                pass_done_o,
    output logic                err_timeout_o
);

    localparam logic [IDX_W:0]   NUM_MAX  = (IDX_W+1)'(STEP_MAX);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(STEP_MAX - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACK_LOW,
        DWELL,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [STEP_MAX-1:0] axis_q, axis_d;
    logic [CNT_W-1:0]    dwell_q, dwell_d;
    logic [CNT_W-1:0]    tmo_q, tmo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    wait_q, wait_d;
    logic                ack_q;
    logic [1:0]          sw_req_q, sw_req_d;
    logic                step_done_q, step_done_d;
    logic                pass_done_q, pass_done_d;
    logic                err_q, err_d;
    logic                expire;
    logic                ack_rise;

    // Step count clamped into 1..STEP_MAX, stored as the index of the last step.
    function automatic logic [IDX_W-1:0] last_idx(input logic [IDX_W:0] n);
        if (n == '0)
            return '0;
        else if (n > NUM_MAX)
            return IDX_LAST;
        else
            return IDX_W'(n - (IDX_W+1)'(1));
    endfunction

    assign expire   = (tmo_q != '0) && ((wait_q + CNT_W'(1)) == tmo_q);
    // A request only accepts a fresh rising ack, never one left high from before.
    assign ack_rise = sw_if.sw_ack && !ack_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        last_d      = last_q;
        axis_d      = axis_q;
        dwell_d     = dwell_q;
        tmo_d       = tmo_q;
        cnt_d       = cnt_q;
        wait_d      = '0;
        step_done_d = 1'b0;
        pass_done_d = 1'b0;
        err_d       = 1'b0;

        if (abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i && !abort_i) begin
                        state_d = REQ;
                        idx_d   = '0;
                        last_d  = last_idx(reg_step_num_i);
                        axis_d  = reg_axis_seq_i;
                        dwell_d = reg_dwell_time_i;
                        tmo_d   = reg_timeout_i;
                    end
                end
                REQ: begin
                    if (ack_rise) begin
                        state_d = ACK_LOW;
                    end else if (expire) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else begin
                        wait_d = wait_q + CNT_W'(1);
                    end
                end
                ACK_LOW: begin
                    if (!sw_if.sw_ack) begin
                        state_d = DWELL;
                        cnt_d   = dwell_q;
                    end else if (expire) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else begin
                        wait_d = wait_q + CNT_W'(1);
                    end
                end
                DWELL: begin
                    if (cnt_q == '0) begin
                        step_done_d = 1'b1;
                        if (idx_q == last_q) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = REQ;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    pass_done_d = 1'b1;
`ifdef SW_SCAN_SCHED_LOOP_EN
                    state_d = REQ;
                    idx_d   = '0;
                    last_d  = last_idx(reg_step_num_i);
                    axis_d  = reg_axis_seq_i;
                    dwell_d = reg_dwell_time_i;
                    tmo_d   = reg_timeout_i;
`else
                    state_d = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end

        sw_req_d = 2'b00;
        if (state_d == REQ)
            sw_req_d = axis_d[idx_d] ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            last_q      <= '0;
            axis_q      <= '0;
            dwell_q     <= '0;
            tmo_q       <= '0;
            cnt_q       <= '0;
            wait_q      <= '0;
            ack_q       <= 1'b0;
            sw_req_q    <= 2'b00;
            step_done_q <= 1'b0;
            pass_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            axis_q      <= axis_d;
            dwell_q     <= dwell_d;
            tmo_q       <= tmo_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            ack_q       <= sw_if.sw_ack;
            sw_req_q    <= sw_req_d;
            step_done_q <= step_done_d;
            pass_done_q <= pass_done_d;
            err_q       <= err_d;
        end
    end

    assign sw_if.sw_req  = sw_req_q;
    assign busy_o        = (state_q != IDLE);
    assign step_idx_o    = idx_q;
    assign step_done_o   = step_done_q;
    assign pass_done_o   = pass_done_q;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_sw_scan_sched.sv
// Directed and randomized checks of sw_scan_sched against a step-level reference model.
module tb_sw_scan_sched;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [4:0]  reg_step_num;
    logic [15:0] reg_axis_seq;
    logic [31:0] reg_dwell_time;
    logic [31:0] reg_timeout;
    logic        busy;
    logic [3:0]  step_idx;
    logic        step_done;
    logic        pass_done;
    logic        err_timeout;

    int n_cmp = 0;
    int n_err = 0;

    sw_scan_sched_if sif ();

    sw_scan_sched #(.STEP_MAX(16), .CNT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start),
        .abort_i         (abort),
        .reg_step_num_i  (reg_step_num),
        .reg_axis_seq_i  (reg_axis_seq),
        .reg_dwell_time_i(reg_dwell_time),
        .reg_timeout_i   (reg_timeout),
        .sw_if           (sif),
        .busy_o          (busy),
        .step_idx_o      (step_idx),
        .step_done_o     (step_done),
        .pass_done_o     (pass_done),
        .err_timeout_o   (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: number of steps a pass executes for a programmed step count.
    function automatic int model_steps(input int num);
        if (num == 0) return 1;
        if (num > 16) return 16;
        return num;
    endfunction

    function automatic logic [1:0] model_req(input logic [15:0] axis, input int i);
        return axis[i] ? 2'b10 : 2'b01;
    endfunction

    // Cycles from the edge that samples ack low up to step_done: that edge plus dwell+1 DWELL cycles.
    function automatic int model_lat(input int dwell);
        return dwell + 2;
    endfunction

    task automatic start_pass(input int num, input logic [15:0] axis, input int dwell, input int tmo);
        reg_step_num   = 5'(num);
        reg_axis_seq   = axis;
        reg_dwell_time = dwell;
        reg_timeout    = tmo;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_step_done(input string tag, input int exp_lat, input int already);
        int k;
        k = already;
        while (!step_done && k < 300) begin
            tick();
            k++;
        end
        check(tag, k, exp_lat);
    endtask

    task automatic run_pass(input int num, input logic [15:0] axis, input int dwell, input int tmo);
        int n;
        int d;
        int l;
        n = model_steps(num);
        start_pass(num, axis, dwell, tmo);
        // Later register traffic must not disturb the latched pass.
        reg_step_num   = 5'($urandom);
        reg_axis_seq   = 16'($urandom);
        reg_dwell_time = $urandom_range(20, 60);
        reg_timeout    = $urandom_range(2, 5);
        check("busy_start", busy, 1'b1);
        for (int i = 0; i < n; i++) begin
            check("req_val", sif.sw_req, model_req(axis, i));
            check("step_idx", step_idx, i);
            if (sif.sw_req !== model_req(axis, i)) return;
            d = $urandom_range(0, 4);
            repeat (d) tick();
            sif.sw_ack = 1'b1;
            tick();
            check("req_drop", sif.sw_req, 2'b00);
            l = $urandom_range(1, 3);
            repeat (l - 1) tick();
            sif.sw_ack = 1'b0;
            tick();
            wait_step_done("dwell_lat", model_lat(dwell), 1);
            if (!step_done) return;
        end
        check("pass_early", pass_done, 1'b0);
        tick();
        check("pass_done", pass_done, 1'b1);
        check("busy_end", busy, 1'b0);
        check("idx_hold", step_idx, n - 1);
        check("req_idle", sif.sw_req, 2'b00);
        tick();
        check("pass_once", pass_done, 1'b0);
    endtask

    initial begin
        int  k;
        bit  seen;
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        sif.sw_ack = 1'b0;
        reg_step_num = '0;
        reg_axis_seq = '0;
        reg_dwell_time = '0;
        reg_timeout = '0;
        repeat (3) tick();
        check("rst_req", sif.sw_req, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_idx", step_idx, 0);
        check("rst_sdone", step_done, 1'b0);
        check("rst_pdone", pass_done, 1'b0);
        check("rst_err", err_timeout, 1'b0);
        rst = 1'b1;
        tick();

        run_pass(3, 16'b010, 4, 0);
        run_pass(0, 16'($urandom), 1, 0);
        run_pass(20, 16'($urandom), 0, 0);
        for (int r = 0; r < 6; r++)
            run_pass($urandom_range(0, 20), 16'($urandom), $urandom_range(0, 6),
                     ($urandom_range(0, 1) == 0) ? 0 : 1000);

        // Timeout while waiting for the ack to rise.
        start_pass(1, 16'h0, 0, 20);
        check("to_req_on", sif.sw_req, 2'b01);
        k = 0;
        while (!err_timeout && k < 100) begin
            tick();
            k++;
        end
        check("to_req_cyc", k, 20);
        check("to_req_off", sif.sw_req, 2'b00);
        check("to_busy", busy, 1'b0);
        check("to_nopass", pass_done, 1'b0);
        tick();
        check("to_pulse", err_timeout, 1'b0);

        // Timeout while waiting for the ack to fall.
        start_pass(1, 16'h1, 0, 10);
        tick();
        sif.sw_ack = 1'b1;
        tick();
        check("tol_req", sif.sw_req, 2'b00);
        k = 0;
        while (!err_timeout && k < 100) begin
            tick();
            k++;
        end
        check("tol_cyc", k, 10);
        check("tol_busy", busy, 1'b0);
        sif.sw_ack = 1'b0;
        tick();

        // Ack arriving on the expiry edge wins over the timeout.
        start_pass(1, 16'h1, 2, 8);
        repeat (7) tick();
        sif.sw_ack = 1'b1;
        tick();
        check("race_err", err_timeout, 1'b0);
        check("race_req", sif.sw_req, 2'b00);
        check("race_busy", busy, 1'b1);
        sif.sw_ack = 1'b0;
        tick();
        wait_step_done("race_lat", model_lat(2), 1);
        tick();
        check("race_pass", pass_done, 1'b1);

        // Ack left high into the next step must drop and rise again.
        start_pass(2, 16'b0001, 3, 0);
        check("stk_req0", sif.sw_req, 2'b10);
        sif.sw_ack = 1'b1;
        tick();
        sif.sw_ack = 1'b0;
        tick();
        sif.sw_ack = 1'b1;
        wait_step_done("stk_lat0", model_lat(3), 1);
        check("stk_req1", sif.sw_req, 2'b01);
        repeat (6) tick();
        check("stk_hold", sif.sw_req, 2'b01);
        check("stk_idx", step_idx, 1);
        sif.sw_ack = 1'b0;
        tick();
        check("stk_low", sif.sw_req, 2'b01);
        sif.sw_ack = 1'b1;
        tick();
        check("stk_acc", sif.sw_req, 2'b00);
        sif.sw_ack = 1'b0;
        tick();
        wait_step_done("stk_lat1", model_lat(3), 1);
        tick();
        check("stk_pass", pass_done, 1'b1);

        // Abort during the dwell of step 1 of 4.
        start_pass(4, 16'h0, 5, 0);
        sif.sw_ack = 1'b1;
        tick();
        sif.sw_ack = 1'b0;
        tick();
        wait_step_done("ab_lat0", model_lat(5), 1);
        check("ab_idx1", step_idx, 1);
        sif.sw_ack = 1'b1;
        tick();
        sif.sw_ack = 1'b0;
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_req", sif.sw_req, 2'b00);
        check("ab_busy", busy, 1'b0);
        seen = step_done | pass_done;
        repeat (10) begin
            tick();
            seen = seen | step_done | pass_done;
        end
        check("ab_quiet", seen, 1'b0);
        check("ab_idx", step_idx, 1);

        // Abort beats an ack on the same edge.
        start_pass(2, 16'h0, 0, 0);
        sif.sw_ack = 1'b1;
        abort = 1'b1;
        tick();
        sif.sw_ack = 1'b0;
        abort = 1'b0;
        check("abk_busy", busy, 1'b0);
        check("abk_req", sif.sw_req, 2'b00);

        // Start together with abort in IDLE stays idle.
        abort = 1'b1;
        start_pass(2, 16'h0, 0, 0);
        abort = 1'b0;
        check("sa_busy", busy, 1'b0);
        check("sa_req", sif.sw_req, 2'b00);

        // Reset while a request is up, then a clean pass.
        start_pass(3, 16'h0, 1, 0);
        check("rm_req", sif.sw_req, 2'b01);
        rst = 1'b0;
        tick();
        check("rm_drop", sif.sw_req, 2'b00);
        check("rm_busy", busy, 1'b0);
        rst = 1'b1;
        tick();
        run_pass(2, 16'($urandom), $urandom_range(0, 3), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
